// File: rtl/snn_pkt_pkg.sv
// Shared packet layout, FSM state encoding and leak constant for the SNN conv datapath.
package snn_pkt_pkg;

    localparam int PKT_W      = 32;
    localparam int DEST_HI    = 31;
    localparam int DEST_LO    = 28;
    localparam int SRC_HI     = 27;
    localparam int SRC_LO     = 24;
    localparam int ROW_HI     = 20;
    localparam int ROW_LO     = 16;
    localparam int SPIKE_BIT  = 13;
    localparam int DATA_HI    = 12;
    localparam int DATA_LO    = 0;
    localparam int LEAK_SHIFT = 3;

    typedef logic [PKT_W-1:0] pkt_t;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        UPDATE = 2'd1,
        SEND   = 2'd2
    } state_t;

    // Unused fields of a result packet are forced to zero.
    function automatic pkt_t make_result(
        input logic [DEST_HI-DEST_LO:0] dest,
        input logic [SRC_HI-SRC_LO:0]   src,
        input logic [ROW_HI-ROW_LO:0]   row,
        input logic                     spike,
        input logic [DATA_HI-DATA_LO:0] data
    );
        pkt_t p;
        p                   = '0;
        p[DEST_HI:DEST_LO]  = dest;
        p[SRC_HI:SRC_LO]    = src;
        p[ROW_HI:ROW_LO]    = row;
        p[SPIKE_BIT]        = spike;
        p[DATA_HI:DATA_LO]  = data;
        return p;
    endfunction

endpackage

// File: rtl/psum_threshold.sv
// Combinational neuron update: optional leak, add, threshold compare, subtract and saturate.
// Optional macro LEAK_EN leaks the stored residue by r >> LEAK_SHIFT before the add.
module psum_threshold
    import snn_pkt_pkg::*;
#(
    parameter int                    WIDTH_DATA = 13,
    parameter int                    WIDTH_ACC  = 16,
    parameter logic [WIDTH_DATA-1:0] THRE       = 13'd64
) (
    input  logic [WIDTH_ACC-1:0]  acc,
    input  logic [WIDTH_DATA-1:0] residue,
    output logic                  spike,
    output logic [WIDTH_DATA-1:0] new_residue
);

    localparam int TOT_W = WIDTH_ACC + 1;
    localparam logic [WIDTH_DATA-1:0] SAT_MAX = {WIDTH_DATA{1'b1}};

    logic [WIDTH_DATA-1:0] leaked_s;
    logic [TOT_W-1:0]      total_s;
    logic [TOT_W-1:0]      diff_s;

    // Total, fire decision and the saturated residue left behind.
    always_comb begin
`ifdef LEAK_EN
        leaked_s = residue - (residue >> LEAK_SHIFT);
`else
        leaked_s = residue;
`endif
        total_s = {1'b0, acc} + TOT_W'(leaked_s);
        spike   = (total_s > TOT_W'(THRE));
        if (spike) begin
            diff_s = total_s - TOT_W'(THRE);
        end else begin
            diff_s = total_s;
        end
        if (diff_s > TOT_W'(SAT_MAX)) begin
            new_residue = SAT_MAX;
        end else begin
            new_residue = diff_s[WIDTH_DATA-1:0];
        end
    end

endmodule

// File: rtl/psum_spike_unit.sv
// Collects N_PSUM partial sums per neuron, adds the stored residue, thresholds and emits a result packet.
// Optional macro LEAK_EN (in psum_threshold) enables residue leak; the port list does not change.
module psum_spike_unit
    import snn_pkt_pkg::*;
#(
    parameter int                    WIDTH_DATA  = 13,
    parameter int                    WIDTH_PKT   = 32,
    parameter int                    DEPTH_R     = 21,
    parameter int                    N_PSUM      = 5,
    parameter logic [WIDTH_DATA-1:0] THRE        = 13'd64,
    parameter logic [3:0]            OWN_ADDR    = 4'd0,
    parameter logic [3:0]            RESULT_ADDR = 4'd15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH_PKT-1:0] in_pkt,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH_PKT-1:0] out_pkt,
    output logic                 ts_done,
    output logic                 err
);

    localparam int NEURONS = DEPTH_R * DEPTH_R;
    localparam int ACC_W   = WIDTH_DATA + $clog2(N_PSUM);
    localparam int ROW_W   = ROW_HI - ROW_LO + 1;
    localparam int COL_W   = $clog2(DEPTH_R + 1);
    localparam int IDX_W   = $clog2(NEURONS);
    localparam int RCNT_W  = $clog2(NEURONS + 1);
    localparam int PCNT_W  = $clog2(N_PSUM + 1);

    state_t                state_r;
    logic [ACC_W-1:0]      acc_r;
    logic [ROW_W-1:0]      row_r;
    logic [PCNT_W-1:0]     psum_cnt_r;
    logic [RCNT_W-1:0]     res_cnt_r;
    logic [COL_W-1:0]      col_cnt_r [DEPTH_R];
    logic [WIDTH_DATA-1:0] residue_r [NEURONS];

    logic [ROW_W-1:0]      in_row_s;
    logic [WIDTH_DATA-1:0] in_psum_s;
    logic                  accept_s;
    logic                  row_ok_s;
    logic                  col_full_s;
    logic                  mismatch_s;
    logic                  illegal_s;
    logic [COL_W-1:0]      upd_col_s;
    logic [IDX_W-1:0]      upd_idx_s;
    logic [WIDTH_DATA-1:0] upd_res_s;
    logic                  spike_s;
    logic [WIDTH_DATA-1:0] new_res_s;
    logic                  unused_s;

    // Routing fields of incoming packets are not needed by this stage.
    assign unused_s = ^{in_pkt[WIDTH_PKT-1:ROW_HI+1], in_pkt[ROW_LO-1:DATA_HI+1]};

    // Input decode, legality checks and residue lookup for the neuron being updated.
    always_comb begin
        in_row_s   = in_pkt[ROW_HI:ROW_LO];
        in_psum_s  = in_pkt[DATA_HI:DATA_LO];
        accept_s   = in_valid & in_ready;
        row_ok_s   = (in_row_s < ROW_W'(DEPTH_R));
        col_full_s = 1'b0;
        if (row_ok_s) begin
            col_full_s = (col_cnt_r[in_row_s] == COL_W'(DEPTH_R));
        end else begin
            col_full_s = 1'b0;
        end
        mismatch_s = (psum_cnt_r != '0) && (in_row_s != row_r);
        illegal_s  = !row_ok_s || mismatch_s || col_full_s;
        upd_col_s  = col_cnt_r[row_r];
        upd_idx_s  = IDX_W'(row_r) * IDX_W'(DEPTH_R) + IDX_W'(upd_col_s);
        upd_res_s  = residue_r[upd_idx_s];
    end

    psum_threshold #(
        .WIDTH_DATA (WIDTH_DATA),
        .WIDTH_ACC  (ACC_W),
        .THRE       (THRE)
    ) u_threshold (
        .acc         (acc_r),
        .residue     (upd_res_s),
        .spike       (spike_s),
        .new_residue (new_res_s)
    );

    // Neuron FSM with its counters, residue store and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ACCUM;
            acc_r      <= '0;
            row_r      <= '0;
            psum_cnt_r <= '0;
            res_cnt_r  <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_pkt    <= '0;
            ts_done    <= 1'b0;
            err        <= 1'b0;
            for (int i = 0; i < DEPTH_R; i++) begin
                col_cnt_r[i] <= '0;
            end
            for (int i = 0; i < NEURONS; i++) begin
                residue_r[i] <= '0;
            end
        end else begin
            ts_done <= 1'b0;
            case (state_r)
                ACCUM: begin
                    if (accept_s) begin
                        if (illegal_s) begin
                            // Drop the packet and any partial neuron; stored state is untouched.
                            psum_cnt_r <= '0;
                            acc_r      <= '0;
                            err        <= 1'b1;
                        end else begin
                            row_r <= in_row_s;
                            if (psum_cnt_r == '0) begin
                                acc_r <= ACC_W'(in_psum_s);
                            end else begin
                                acc_r <= acc_r + ACC_W'(in_psum_s);
                            end
                            if (psum_cnt_r == PCNT_W'(N_PSUM - 1)) begin
                                psum_cnt_r <= '0;
                                in_ready   <= 1'b0;
                                state_r    <= UPDATE;
                            end else begin
                                psum_cnt_r <= psum_cnt_r + PCNT_W'(1);
                            end
                        end
                    end
                end
                UPDATE: begin
                    residue_r[upd_idx_s] <= new_res_s;
                    col_cnt_r[row_r]     <= upd_col_s + COL_W'(1);
                    out_pkt   <= WIDTH_PKT'(make_result(RESULT_ADDR, OWN_ADDR, row_r, spike_s, new_res_s));
                    out_valid <= 1'b1;
                    state_r   <= SEND;
                end
                SEND: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_r   <= ACCUM;
                        if (res_cnt_r == RCNT_W'(NEURONS - 1)) begin
                            res_cnt_r <= '0;
                            ts_done   <= 1'b1;
                            for (int i = 0; i < DEPTH_R; i++) begin
                                col_cnt_r[i] <= '0;
                            end
                        end else begin
                            res_cnt_r <= res_cnt_r + RCNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_r    <= ACCUM;
                    in_ready   <= 1'b1;
                    out_valid  <= 1'b0;
                    psum_cnt_r <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_psum_spike_unit.sv
// Directed, table-driven self-checking bench for psum_spike_unit.
module tb_psum_spike_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pkt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pkt;
    logic        ts_done;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;
    int results = 0;
    int col_model [21];

    always #5 clk = ~clk;

    psum_spike_unit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pkt    (in_pkt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pkt   (out_pkt),
        .ts_done   (ts_done),
        .err       (err)
    );

    typedef struct {
        logic [4:0]       row;
        logic [4:0][12:0] ps;
        logic             spike;
        logic [12:0]      res;
    } vec_t;

    vec_t vecs [7];

    function automatic vec_t mk(input logic [4:0] row, input int a, input int b, input int c,
                                input int d, input int e, input logic spike, input int res);
        vec_t v;
        v.row   = row;
        v.ps[0] = a[12:0];
        v.ps[1] = b[12:0];
        v.ps[2] = c[12:0];
        v.ps[3] = d[12:0];
        v.ps[4] = e[12:0];
        v.spike = spike;
        v.res   = res[12:0];
        return v;
    endfunction

    function automatic logic [31:0] exp_pkt(input logic [4:0] row, input logic spike, input logic [12:0] res);
        logic [31:0] p;
        p        = 32'd0;
        p[31:28] = 4'd15;
        p[27:24] = 4'd0;
        p[20:16] = row;
        p[13]    = spike;
        p[12:0]  = res;
        return p;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_pkt(input logic [4:0] row, input logic [12:0] psum);
        in_valid = 1'b1;
        in_pkt   = {4'd0, 4'd3, 3'd0, row, 3'd0, psum};
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic feed(input logic [4:0] row, input logic [4:0][12:0] ps);
        for (int i = 0; i < 5; i++) begin
            send_pkt(row, ps[i]);
        end
    endtask

    task automatic run_neuron(input string name, input logic [4:0] row, input logic [4:0][12:0] ps,
                              input logic spike, input logic [12:0] res, input logic exp_ts);
        int lat;
        feed(row, ps);
        check({name, " in_ready_update"}, 32'(in_ready), 32'd0);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, " latency"}, lat, 32'd2);
        check({name, " pkt"}, out_pkt, exp_pkt(row, spike, res));
        @(posedge clk); #1;
        check({name, " ts_done"}, 32'(ts_done), 32'(exp_ts));
        check({name, " valid_drop"}, 32'(out_valid), 32'd0);
        col_model[row]++;
        results++;
    endtask

    initial begin
        logic [31:0]      held;
        logic [4:0][12:0] zeros;
        int               bad;
        int               lat;

        zeros = '0;
        vecs[0] = mk(5'd0,  10,   20,   30,   5,    4,    1'b1, 5);
        vecs[1] = mk(5'd3,  1,    2,    3,    4,    5,    1'b0, 15);
        vecs[2] = mk(5'd7,  64,   0,    0,    0,    0,    1'b0, 64);
        vecs[3] = mk(5'd20, 13,   13,   13,   13,   13,   1'b1, 1);
        vecs[4] = mk(5'd5,  8191, 8191, 8191, 8191, 8191, 1'b1, 8191);
        vecs[5] = mk(5'd0,  100,  0,    0,    0,    0,    1'b1, 36);
        vecs[6] = mk(5'd3,  0,    0,    0,    0,    0,    1'b0, 0);
        for (int i = 0; i < 21; i++) col_model[i] = 0;

        rst = 1'b1; in_valid = 1'b0; in_pkt = 32'd0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset err", 32'(err), 32'd0);
        check("reset out_pkt", out_pkt, 32'd0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid || ts_done) bad++;
        end
        check("idle no output", bad, 32'd0);

        for (int i = 0; i < 7; i++) begin
            run_neuron($sformatf("vec%0d", i), vecs[i].row, vecs[i].ps, vecs[i].spike, vecs[i].res, 1'b0);
        end
        check("err after legal", 32'(err), 32'd0);

        // Backpressure: result held for 10 cycles, accepted on first ready cycle.
        out_ready = 1'b0;
        feed(5'd10, {13'd20, 13'd20, 13'd20, 13'd20, 13'd20});
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp latency", lat, 32'd2);
        held = out_pkt;
        check("bp pkt", held, exp_pkt(5'd10, 1'b1, 13'd36));
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_pkt !== held || !out_valid || in_ready) bad++;
        end
        check("bp stable", bad, 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp accepted", 32'(out_valid), 32'd0);
        check("bp in_ready back", 32'(in_ready), 32'd1);
        col_model[10]++;
        results++;

        // Fill the timestep; after row 1 is full an extra row-1 packet is illegal.
        bad = 0;
        for (int r = 0; r < 21; r++) begin
            while (col_model[r] < 21) begin
                run_neuron("fill", r[4:0], zeros, 1'b0, 13'd0, results == 440);
            end
            if (r == 1) begin
                send_pkt(5'd1, 13'd7);
                check("col full err", 32'(err), 32'd1);
            end
        end
        check("results in timestep", results, 32'd441);
        for (int i = 0; i < 21; i++) col_model[i] = 0;

        // Carry-over into timestep 2.
        run_neuron("carry fire", 5'd0, {13'd12, 13'd12, 13'd12, 13'd12, 13'd12}, 1'b1, 13'd1, 1'b0);
        run_neuron("carry exact64", 5'd8, {13'd0, 13'd0, 13'd0, 13'd0, 13'd64}, 1'b0, 13'd64, 1'b0);

        // Reset clears residue and err; then illegal row and mismatched row.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst2 err", 32'(err), 32'd0);
        run_neuron("post reset", 5'd0, {13'd0, 13'd0, 13'd0, 13'd0, 13'd64}, 1'b0, 13'd64, 1'b0);
        send_pkt(5'd21, 13'd5);
        check("row21 err", 32'(err), 32'd1);
        check("row21 no out", 32'(out_valid), 32'd0);
        send_pkt(5'd2, 13'd100);
        send_pkt(5'd2, 13'd100);
        send_pkt(5'd4, 13'd100);
        run_neuron("after mismatch", 5'd2, {13'd0, 13'd0, 13'd0, 13'd0, 13'd70}, 1'b1, 13'd6, 1'b0);
        check("err sticky", 32'(err), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
